// File: rtl/block_pixel_shader_pkg.sv
// Shared types and constants for the block pixel shader: colour type,
// arrow direction encoding, fp32 field layout and fixed colours.
package block_shader_pkg;

  typedef logic [11:0] rgb12_t;

  // Codes 4-7 all draw a centre dot, so only bit 2 matters for them.
  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_DOT   = 3'd4
  } block_dir_e;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam rgb12_t COLOR_ARROW = 12'hFFF;

  function automatic rgb12_t face_rgb(input logic blue, input logic [3:0] shade);
    face_rgb = blue ? {8'h00, shade} : {shade, 8'h00};
  endfunction

endpackage

// File: rtl/block_pixel_shader_fp32_to_int13.sv
// Combinational fp32 -> signed 13-bit integer, truncating toward zero.
// Magnitudes below 1.0 give 0; beyond 4095, Inf and NaN saturate by sign.
module fp32_to_int13
  import block_shader_pkg::*;
(
  input  logic [31:0]        fp,
  output logic signed [12:0] val
);

  logic                sign;
  logic [FP_EXP_W-1:0] expo;
  logic [FP_MAN_W-1:0] man;
  logic [7:0]          shamt;
  logic [11:0]         mag;

  assign sign = fp[31];
  assign expo = fp[30:23];
  assign man  = fp[22:0];

  always_comb begin
    shamt = 8'd150 - expo;
    mag   = 12'(({1'b1, man}) >> shamt);
    if (expo > 8'd138) begin
      val = sign ? -13'sd4095 : 13'sd4095;
    end else if (expo < 8'(FP_BIAS)) begin
      val = 13'sd0;
    end else begin
      val = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end
  end

endmodule

// File: rtl/block_pixel_shader.sv
// Block pixel shader: 3-stage colour pipeline feeding a show-ahead output FIFO.
// Optional depth fog on face colour when BLOCK_SHADER_DEPTH_FOG_EN is defined.
module block_pixel_shader
  import block_shader_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [11:0] BLOCK_HALF = 12'd100,
  parameter logic [11:0] ARROW_W    = 12'd24,
  parameter int         DEPTH_SHIFT = 4,
  parameter logic [3:0] MIN_SHADE   = 4'd3,
  parameter rgb12_t     BG_COLOR    = 12'h000,
  parameter rgb12_t     SABER_COLOR = 12'hFF0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        valid_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [31:0] ray_x_in,
  input  logic [31:0] ray_y_in,
  input  logic [11:0] block_x_in,
  input  logic [11:0] block_y_in,
  input  logic [13:0] block_z_in,
  input  logic        block_color_in,
  input  logic [2:0]  block_dir_in,
  input  logic        block_visible_in,
  input  logic        saber_visible_in,
  output logic        pix_valid_out,
  input  logic        pix_ready_in,
  output logic [10:0] pix_x_out,
  output logic [9:0]  pix_y_out,
  output logic [11:0] pix_color_out,
  output logic        overflow_out,
  output logic [7:0]  drop_count_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [13:0] HALF_Q = 14'(BLOCK_HALF >> 1);
  localparam logic signed [13:0] BAND_Q = 14'(BLOCK_HALF - ARROW_W);
  localparam logic signed [13:0] DOT_Q  = 14'(ARROW_W);

  // S1: float conversion
  logic signed [12:0] hx_c, hy_c;
  fp32_to_int13 u_cvt_x (.fp(ray_x_in), .val(hx_c));
  fp32_to_int13 u_cvt_y (.fp(ray_y_in), .val(hy_c));

  logic               s1_valid, s2_valid, s3_valid;
  logic [10:0]        s1_x, s2_x, s3_x;
  logic [9:0]         s1_y, s2_y, s3_y;
  logic signed [12:0] s1_hx, s1_hy;
  logic [11:0]        s1_bx, s1_by;
  logic               s1_color, s2_color;
  logic [2:0]         s1_dir;
  logic               s1_bvis, s2_bvis, s1_svis, s2_svis;
  logic               s2_arrow;
  rgb12_t             s3_rgb;
`ifdef BLOCK_SHADER_DEPTH_FOG_EN
  logic [13:0]        s1_z, s2_z;
`endif

  // S2: face-relative coordinates and arrow test (14 bits so u/v never wrap)
  logic signed [13:0] u, v, au, av;
  logic               arrow_c;
  always_comb begin
    u  = {s1_hx[12], s1_hx} - $signed({2'b00, s1_bx});
    v  = {s1_hy[12], s1_hy} - $signed({2'b00, s1_by});
    au = (u < 0) ? -u : u;
    av = (v < 0) ? -v : v;
    arrow_c = 1'b0;
    if (s1_dir[2]) begin
      arrow_c = (au < DOT_Q) && (av < DOT_Q);
    end else begin
      case (s1_dir[1:0])
        DIR_UP[1:0]:   arrow_c = (au < HALF_Q) && (v >= BAND_Q);
        DIR_DOWN[1:0]: arrow_c = (au < HALF_Q) && (v <= -BAND_Q);
        DIR_LEFT[1:0]: arrow_c = (av < HALF_Q) && (u <= -BAND_Q);
        default:       arrow_c = (av < HALF_Q) && (u >= BAND_Q);
      endcase
    end
  end

  // S3: shade and colour priority
  logic [3:0] shade;
  rgb12_t     rgb_c;
`ifdef BLOCK_SHADER_DEPTH_FOG_EN
  logic [13:0] z_sh;
  logic [3:0]  atten, dimmed;
`endif
  always_comb begin
`ifdef BLOCK_SHADER_DEPTH_FOG_EN
    z_sh   = s2_z >> DEPTH_SHIFT;
    atten  = (z_sh > 14'd15) ? 4'hF : z_sh[3:0];
    dimmed = 4'hF - atten;
    shade  = (dimmed < MIN_SHADE) ? MIN_SHADE : dimmed;
`else
    shade  = 4'hF;
`endif
    if (s2_svis)                   rgb_c = SABER_COLOR;
    else if (s2_bvis && s2_arrow)  rgb_c = COLOR_ARROW;
    else if (s2_bvis)              rgb_c = face_rgb(s2_color, shade);
    else                           rgb_c = BG_COLOR;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk_in) begin
    s1_x <= x_in;            s1_y <= y_in;
    s1_hx <= hx_c;           s1_hy <= hy_c;
    s1_bx <= block_x_in;     s1_by <= block_y_in;
    s1_color <= block_color_in;
    s1_dir <= block_dir_in;
    s1_bvis <= block_visible_in;
    s1_svis <= saber_visible_in;
    s2_x <= s1_x;            s2_y <= s1_y;
    s2_arrow <= arrow_c;     s2_color <= s1_color;
    s2_bvis <= s1_bvis;      s2_svis <= s1_svis;
    s3_x <= s2_x;            s3_y <= s2_y;
    s3_rgb <= rgb_c;
`ifdef BLOCK_SHADER_DEPTH_FOG_EN
    s1_z <= block_z_in;
    s2_z <= s1_z;
`endif
  end

  // Output handshake: a pixel transfers on any clk_in edge where
  // pix_valid_out && pix_ready_in; head data is stable while valid && !ready.
  logic [32:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && pix_ready_in;
  assign push  = s3_valid && (!full || pop);

  assign pix_valid_out = !empty;
  assign {pix_x_out, pix_y_out, pix_color_out} = empty ? 33'd0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow_out   <= 1'b0;
      drop_count_out <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (s3_valid && full && !pop) begin
        overflow_out <= 1'b1;
        if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s3_x, s3_y, s3_rgb};
  end

endmodule

// File: tb/tb_block_pixel_shader.sv
// Directed self-checking bench for block_pixel_shader (colours, latency,
// FIFO overflow/full-pop, reset); fog expectations follow BLOCK_SHADER_DEPTH_FOG_EN.
module tb_block_pixel_shader;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        valid_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [31:0] ray_x_in, ray_y_in;
  logic [11:0] block_x_in, block_y_in;
  logic [13:0] block_z_in;
  logic        block_color_in;
  logic [2:0]  block_dir_in;
  logic        block_visible_in, saber_visible_in;
  logic        pix_valid_out, pix_ready_in;
  logic [10:0] pix_x_out;
  logic [9:0]  pix_y_out;
  logic [11:0] pix_color_out;
  logic        overflow_out;
  logic [7:0]  drop_count_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  localparam logic [31:0] F_300 = 32'h43960000;
  localparam logic [31:0] F_390 = 32'h43C30000;
  localparam logic [31:0] F_420 = 32'h43D20000;
  localparam logic [31:0] F_450 = 32'h43E10000;
  localparam logic [31:0] F_500 = 32'h43FA0000;
  localparam logic [31:0] F_1E6 = 32'h49742400;
  localparam logic [31:0] F_NAN = 32'h7FC00000;

  block_pixel_shader dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in),
    .x_in(x_in), .y_in(y_in), .ray_x_in(ray_x_in), .ray_y_in(ray_y_in),
    .block_x_in(block_x_in), .block_y_in(block_y_in), .block_z_in(block_z_in),
    .block_color_in(block_color_in), .block_dir_in(block_dir_in),
    .block_visible_in(block_visible_in), .saber_visible_in(saber_visible_in),
    .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
    .pix_x_out(pix_x_out), .pix_y_out(pix_y_out), .pix_color_out(pix_color_out),
    .overflow_out(overflow_out), .drop_count_out(drop_count_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    pix_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
  endtask

  // driver: one input cycle; called at #1 after an edge, returns #1 after the next
  task automatic put(input logic [10:0] x, input logic [31:0] rx, input logic [31:0] ry,
                     input logic [11:0] bx, input logic [11:0] by, input logic [13:0] bz,
                     input logic col, input logic [2:0] dir, input logic bvis, input logic svis);
    x_in = x; y_in = 10'(x) ^ 10'h155;
    ray_x_in = rx; ray_y_in = ry;
    block_x_in = bx; block_y_in = by; block_z_in = bz;
    block_color_in = col; block_dir_in = dir;
    block_visible_in = bvis; saber_visible_in = svis;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  // bounded wait for head, capture it, pop it
  task automatic get_pixel(output logic ok, output logic [32:0] pix);
    ok = 1'b0;
    pix = '0;
    for (int i = 0; i < 20; i++) begin
      if (pix_valid_out) begin
        pix = {pix_x_out, pix_y_out, pix_color_out};
        pix_ready_in = 1'b1;
        @(posedge clk_in); #1;
        pix_ready_in = 1'b0;
        ok = 1'b1;
        break;
      end
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({pix_valid_out, pix_x_out, pix_y_out, pix_color_out, overflow_out, drop_count_out} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b x=%0d y=%0d c=%h ov=%b dc=%0d, want all 0",
               pix_valid_out, pix_x_out, pix_y_out, pix_color_out, overflow_out, drop_count_out);
    end
  endtask

  task automatic test_arrow_latency();
    @(posedge clk_in); #1;
    put(11'd7, F_500, F_390, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    repeat (2) @(posedge clk_in);
    #1;
    n_checks++;
    if (pix_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: pix_valid=%b want 0 three edges after input", pix_valid_out);
    end
    @(posedge clk_in); #1;
    n_checks++;
    if (pix_valid_out !== 1'b1) begin
      n_fail++; $display("FAIL latency_on_time: pix_valid=%b want 1 four edges after input", pix_valid_out);
    end
    n_checks++;
    if ({pix_x_out, pix_y_out, pix_color_out} !== {11'd7, 10'd7 ^ 10'h155, 12'hFFF}) begin
      n_fail++; $display("FAIL arrow_up: got x=%0d y=%0d c=%h want x=7 y=%0d c=fff",
                         pix_x_out, pix_y_out, pix_color_out, 10'd7 ^ 10'h155);
    end
    pix_ready_in = 1'b1;
    @(posedge clk_in); #1;
    pix_ready_in = 1'b0;
    n_checks++;
    if (pix_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL pop_empty: pix_valid=%b want 0 after single pop", pix_valid_out);
    end
  endtask

  task automatic test_face_colors();
    logic ok;
    logic [32:0] pix;
    logic [11:0] exp_c [5];
    exp_c = '{12'hF00, 12'h00F, 12'h000, 12'hFFF, 12'hFFF};
    put(11'd20, F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    put(11'd21, F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    put(11'd22, F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    put(11'd23, F_420, F_300, 12'd500, 12'd300, 14'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    put(11'd24, F_1E6, F_300, 12'd4000, 12'd300, 14'd0, 1'b1, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      get_pixel(ok, pix);
      n_checks++;
      if (!ok || pix[11:0] !== exp_c[i] || pix[32:22] !== 11'(20 + i)) begin
        n_fail++; $display("FAIL face_color[%0d]: ok=%b x=%0d c=%h want x=%0d c=%h",
                           i, ok, pix[32:22], pix[11:0], 20 + i, exp_c[i]);
      end
    end
  endtask

  task automatic test_saber_nan();
    logic ok;
    logic [32:0] pix;
    put(11'd30, F_500, F_390, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b1, 1'b1);
    put(11'd31, F_NAN, F_300, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    get_pixel(ok, pix);
    n_checks++;
    if (!ok || pix[11:0] !== 12'hFF0) begin
      n_fail++; $display("FAIL saber_priority: ok=%b c=%h want ff0", ok, pix[11:0]);
    end
    get_pixel(ok, pix);
    n_checks++;
    if (!ok || pix !== {11'd31, 10'd31 ^ 10'h155, 12'h000}) begin
      n_fail++; $display("FAIL nan_background: ok=%b pix=%h want x=31 c=000", ok, pix);
    end
  endtask

  task automatic test_overflow();
    logic ok;
    logic [32:0] pix, want;
    do_reset();
    @(posedge clk_in); #1;
    for (int i = 0; i < 10; i++) begin
      put(11'(100 + i), F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      if (i < 8) exp_q.push_back({11'(100 + i), 10'(100 + i) ^ 10'h155, 12'hF00});
    end
    repeat (6) @(posedge clk_in);
    #1;
    n_checks++;
    if (overflow_out !== 1'b1 || drop_count_out !== 8'd2) begin
      n_fail++; $display("FAIL overflow_flags: ov=%b dc=%0d want ov=1 dc=2", overflow_out, drop_count_out);
    end
    n_checks++;
    if (pix_valid_out !== 1'b1 || pix_x_out !== 11'd100) begin
      n_fail++; $display("FAIL overflow_hold: v=%b x=%0d want v=1 x=100", pix_valid_out, pix_x_out);
    end
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      get_pixel(ok, pix);
      n_checks++;
      if (!ok || pix !== want) begin
        n_fail++; $display("FAIL drain_order: ok=%b got %h want %h", ok, pix, want);
      end
    end
    n_checks++;
    if (pix_valid_out !== 1'b0 || overflow_out !== 1'b1) begin
      n_fail++; $display("FAIL drain_end: v=%b ov=%b want v=0 ov=1 (sticky)", pix_valid_out, overflow_out);
    end
  endtask

  task automatic test_full_write_pop();
    logic ok;
    logic [32:0] pix;
    do_reset();
    @(posedge clk_in); #1;
    for (int i = 0; i < 8; i++)
      put(11'(200 + i), F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    repeat (4) @(posedge clk_in);
    #1;
    put(11'd208, F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    pix_ready_in = 1'b1;
    @(posedge clk_in); #1;
    pix_ready_in = 1'b0;
    n_checks++;
    if (overflow_out !== 1'b0 || drop_count_out !== 8'd0) begin
      n_fail++; $display("FAIL full_pop_nodrop: ov=%b dc=%0d want 0/0", overflow_out, drop_count_out);
    end
    for (int i = 0; i < 8; i++) begin
      get_pixel(ok, pix);
      n_checks++;
      if (!ok || pix[32:22] !== 11'(201 + i) || pix[11:0] !== 12'h00F) begin
        n_fail++; $display("FAIL full_pop_order[%0d]: ok=%b x=%0d c=%h want x=%0d c=00f",
                           i, ok, pix[32:22], pix[11:0], 201 + i);
      end
    end
    n_checks++;
    if (pix_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_count: v=%b want 0 after 8 pops", pix_valid_out);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++)
      put(11'(300 + i), F_450, F_300, 12'd500, 12'd300, 14'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    rst_n_in = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    n_checks++;
    if (pix_valid_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: v=%b want 0 after reset", pix_valid_out);
    end
    repeat (6) @(posedge clk_in);
    #1;
    n_checks++;
    if (pix_valid_out !== 1'b0 || drop_count_out !== 8'd0) begin
      n_fail++; $display("FAIL reset_inflight: v=%b dc=%0d want 0/0", pix_valid_out, drop_count_out);
    end
  endtask

  task automatic test_fog();
    logic ok;
    logic [32:0] pix;
    logic [11:0] exp_c [3];
`ifdef BLOCK_SHADER_DEPTH_FOG_EN
    exp_c = '{12'h500, 12'h300, 12'hFFF};
`else
    exp_c = '{12'hF00, 12'hF00, 12'hFFF};
`endif
    put(11'd40, F_450, F_300, 12'd500, 12'd300, 14'd160,  1'b0, 3'd0, 1'b1, 1'b0);
    put(11'd41, F_450, F_300, 12'd500, 12'd300, 14'd4000, 1'b0, 3'd0, 1'b1, 1'b0);
    put(11'd42, F_500, F_390, 12'd500, 12'd300, 14'd4000, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      get_pixel(ok, pix);
      n_checks++;
      if (!ok || pix[11:0] !== exp_c[i]) begin
        n_fail++; $display("FAIL fog[%0d]: ok=%b c=%h want %h", i, ok, pix[11:0], exp_c[i]);
      end
    end
  endtask

  initial begin
    rst_n_in = 1'b0; valid_in = 1'b0; pix_ready_in = 1'b0;
    x_in = '0; y_in = '0; ray_x_in = '0; ray_y_in = '0;
    block_x_in = '0; block_y_in = '0; block_z_in = '0;
    block_color_in = 1'b0; block_dir_in = '0;
    block_visible_in = 1'b0; saber_visible_in = 1'b0;
    test_reset();
    test_arrow_latency();
    test_face_colors();
    test_saber_nan();
    test_fog();
    test_overflow();
    test_full_write_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
